// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch stage: branch-wait FSM states and issue-channel indices.
package dispatch_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_BR = 1'b1
    } br_state_t;

    localparam int CH_INT  = 0;
    localparam int CH_LDST = 1;
    localparam int CH_MUL  = 2;
    localparam int CH_DIV  = 3;

endpackage

// File: rtl/dispatch_unit_param_tag_free_list.sv
// Circular free list of rename tags; comes out of reset holding every tag in ascending order.
module tag_free_list #(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pop,
    input  logic                 push,
    input  logic [TAG_WIDTH-1:0] push_tag,
    output logic [TAG_WIDTH-1:0] head_tag,
    output logic                 empty,
    output logic                 full
);

    localparam int DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH + 1)'(DEPTH);

    logic [TAG_WIDTH-1:0] mem [DEPTH];
    logic [TAG_WIDTH-1:0] head;
    logic [TAG_WIDTH-1:0] tail;
    logic [TAG_WIDTH:0]   count;
    logic                 pop_ok;

    assign pop_ok   = pop & ~empty;
    assign head_tag = mem[head];
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);

    // Pointers are exactly TAG_WIDTH bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_WIDTH'(i);
            end
            head  <= '0;
            tail  <= '0;
            count <= DEPTH_CNT;
        end else begin
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            if (push) begin
                mem[tail] <= push_tag;
                tail      <= tail + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_unit_param.sv
// Tomasulo dispatch: tag allocation, register renaming and one-hot issue with branch stall.
// Optional macro DISPATCH_CDB_BYPASS_EN forwards same-cycle CDB data into pending operands.
module dispatch_unit_param
    import dispatch_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CH         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [REG_ADDR_WIDTH-1:0]   inst_rd,
    input  logic [REG_ADDR_WIDTH-1:0]   inst_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]   inst_rs2,
    input  logic                        inst_reg_write,
    input  logic [NUM_CH-1:0]           inst_ch,
    input  logic                        inst_branch,
    input  logic [DATA_WIDTH-1:0]       rf_rs1_data,
    input  logic [DATA_WIDTH-1:0]       rf_rs2_data,
    input  logic [NUM_CH-1:0]           issueque_full,
    input  logic                        cdb_valid,
    input  logic [TAG_WIDTH-1:0]        cdb_tag,
    input  logic [DATA_WIDTH-1:0]       cdb_data,
    input  logic                        cdb_branch,
    output logic [NUM_CH-1:0]           dispatch_en,
    output logic [TAG_WIDTH-1:0]        dispatch_rd_tag,
    output logic [TAG_WIDTH-1:0]        dispatch_rs1_tag,
    output logic [TAG_WIDTH-1:0]        dispatch_rs2_tag,
    output logic                        dispatch_rs1_valid,
    output logic                        dispatch_rs2_valid,
    output logic [DATA_WIDTH-1:0]       dispatch_rs1_data,
    output logic [DATA_WIDTH-1:0]       dispatch_rs2_data,
    output logic [2**REG_ADDR_WIDTH-1:0] rf_write_en
);

    localparam int NREG = 2 ** REG_ADDR_WIDTH;

    br_state_t            state, state_nxt;
    logic                 busy    [NREG];
    logic [TAG_WIDTH-1:0] rst_tag [NREG];
    logic                 free_empty;
    logic                 free_full;
    logic [TAG_WIDTH-1:0] head_tag;
    logic                 accept;
    logic                 alloc;

    assign inst_ready = (state == IDLE) & ~|(inst_ch & issueque_full)
                      & ~(inst_reg_write & free_empty);
    assign accept     = inst_valid & inst_ready;
    // x0 writes are accepted but never consume a tag or mark the RST.
    assign alloc      = accept & inst_reg_write & (inst_rd != '0);

    assign dispatch_en     = accept ? inst_ch : '0;
    assign dispatch_rd_tag = head_tag;

    tag_free_list #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_free_list (
        .clk      (clk),
        .reset    (reset),
        .pop      (alloc),
        .push     (cdb_valid),
        .push_tag (cdb_tag),
        .head_tag (head_tag),
        .empty    (free_empty),
        .full     (free_full)
    );

    always_comb begin
        rf_write_en = '0;
        for (int i = 0; i < NREG; i++) begin
            rf_write_en[i] = cdb_valid & busy[i] & (rst_tag[i] == cdb_tag);
        end
    end

    // Sources see the RST before this instruction's own rd update.
    always_comb begin
        dispatch_rs1_tag   = rst_tag[inst_rs1];
        dispatch_rs1_valid = busy[inst_rs1];
        dispatch_rs1_data  = rf_rs1_data;
        dispatch_rs2_tag   = rst_tag[inst_rs2];
        dispatch_rs2_valid = busy[inst_rs2];
        dispatch_rs2_data  = rf_rs2_data;
`ifdef DISPATCH_CDB_BYPASS_EN
        if (busy[inst_rs1] && cdb_valid && (rst_tag[inst_rs1] == cdb_tag)) begin
            dispatch_rs1_valid = 1'b0;
            dispatch_rs1_data  = cdb_data;
        end
        if (busy[inst_rs2] && cdb_valid && (rst_tag[inst_rs2] == cdb_tag)) begin
            dispatch_rs2_valid = 1'b0;
            dispatch_rs2_data  = cdb_data;
        end
`endif
    end

    // A dispatch to the same register overrides a CDB clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                busy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rf_write_en[i]) begin
                    busy[i] <= 1'b0;
                end
            end
            if (alloc) begin
                busy[inst_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            rst_tag[inst_rd] <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && inst_branch) state_nxt = WAIT_BR;
            WAIT_BR: if (cdb_branch)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every outstanding tag returns exactly once, so a push into a full list means a lost tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(cdb_valid && free_full));
        end
    end

endmodule

// File: tb/tb_dispatch_unit_param.sv
// Self-checking bench for dispatch_unit_param: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_dispatch_unit_param;
    import dispatch_pkg::*;

    localparam int DW   = 32;
    localparam int TW   = 3;
    localparam int RW   = 5;
    localparam int NCH  = 4;
    localparam int NT   = 1 << TW;
    localparam int NREG = 1 << RW;

    logic            clk = 1'b0;
    logic            reset;
    logic            inst_valid;
    logic            inst_ready;
    logic [RW-1:0]   inst_rd, inst_rs1, inst_rs2;
    logic            inst_reg_write;
    logic [NCH-1:0]  inst_ch;
    logic            inst_branch;
    logic [DW-1:0]   rf_rs1_data, rf_rs2_data;
    logic [NCH-1:0]  issueque_full;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            cdb_branch;
    logic [NCH-1:0]  dispatch_en;
    logic [TW-1:0]   dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
    logic            dispatch_rs1_valid, dispatch_rs2_valid;
    logic [DW-1:0]   dispatch_rs1_data, dispatch_rs2_data;
    logic [NREG-1:0] rf_write_en;

    dispatch_unit_param #(
        .DATA_WIDTH     (DW),
        .TAG_WIDTH      (TW),
        .REG_ADDR_WIDTH (RW),
        .NUM_CH         (NCH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .inst_rd            (inst_rd),
        .inst_rs1           (inst_rs1),
        .inst_rs2           (inst_rs2),
        .inst_reg_write     (inst_reg_write),
        .inst_ch            (inst_ch),
        .inst_branch        (inst_branch),
        .rf_rs1_data        (rf_rs1_data),
        .rf_rs2_data        (rf_rs2_data),
        .issueque_full      (issueque_full),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_data           (cdb_data),
        .cdb_branch         (cdb_branch),
        .dispatch_en        (dispatch_en),
        .dispatch_rd_tag    (dispatch_rd_tag),
        .dispatch_rs1_tag   (dispatch_rs1_tag),
        .dispatch_rs2_tag   (dispatch_rs2_tag),
        .dispatch_rs1_valid (dispatch_rs1_valid),
        .dispatch_rs2_valid (dispatch_rs2_valid),
        .dispatch_rs1_data  (dispatch_rs1_data),
        .dispatch_rs2_data  (dispatch_rs2_data),
        .rf_write_en        (rf_write_en)
    );

    always #5 clk = ~clk;

    // Reference model: free tags as a FIFO queue, outstanding tags, per-register mapping.
    int free_q[$];
    int outst_q[$];
    bit m_busy[NREG];
    int m_tag[NREG];
    bit m_br;

    int checks   = 0;
    int failures = 0;

    logic            s_ready;
    logic [NCH-1:0]  s_en;
    logic [TW-1:0]   s_rd_tag, s_rs1_tag, s_rs2_tag;
    logic            s_rs1_valid, s_rs2_valid;
    logic [DW-1:0]   s_rs1_data, s_rs2_data;
    logic [NREG-1:0] s_we;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q  = {};
        outst_q = {};
        for (int i = 0; i < NT; i++) free_q.push_back(i);
        for (int r = 0; r < NREG; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = 0;
        end
        m_br = 1'b0;
    endtask

    task automatic idle_inputs();
        inst_valid     = 1'b0;
        inst_rd        = '0;
        inst_rs1       = '0;
        inst_rs2       = '0;
        inst_reg_write = 1'b0;
        inst_ch        = NCH'(1 << CH_INT);
        inst_branch    = 1'b0;
        rf_rs1_data    = '0;
        rf_rs2_data    = '0;
        issueque_full  = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        cdb_branch     = 1'b0;
    endtask

    task automatic chk_operand(input string name, input int rs, input logic [DW-1:0] rfd,
                               input logic sv, input logic [TW-1:0] st, input logic [DW-1:0] sd);
        bit ev;
        int et;
        logic [DW-1:0] ed;
        ev = m_busy[rs];
        et = m_tag[rs];
        ed = rfd;
`ifdef DISPATCH_CDB_BYPASS_EN
        if (m_busy[rs] && cdb_valid && (m_tag[rs] == int'(cdb_tag))) begin
            ev = 1'b0;
            ed = cdb_data;
        end
`endif
        chk({name, "_valid"}, 64'(sv), 64'(ev));
        if (ev) chk({name, "_tag"}, 64'(st), 64'(et));
        else    chk({name, "_data"}, 64'(sd), 64'(ed));
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic step();
        bit exp_ready, acc, alloc;
        logic [NREG-1:0] exp_we;
        int t;
        @(negedge clk);
        exp_ready = !m_br && ((inst_ch & issueque_full) == '0) &&
                    !(inst_reg_write && free_q.size() == 0);
        acc   = inst_valid && exp_ready;
        alloc = acc && inst_reg_write && (inst_rd != '0);
        exp_we = '0;
        for (int r = 0; r < NREG; r++)
            if (cdb_valid && m_busy[r] && m_tag[r] == int'(cdb_tag)) exp_we[r] = 1'b1;
        s_ready     = inst_ready;
        s_en        = dispatch_en;
        s_rd_tag    = dispatch_rd_tag;
        s_rs1_tag   = dispatch_rs1_tag;
        s_rs2_tag   = dispatch_rs2_tag;
        s_rs1_valid = dispatch_rs1_valid;
        s_rs2_valid = dispatch_rs2_valid;
        s_rs1_data  = dispatch_rs1_data;
        s_rs2_data  = dispatch_rs2_data;
        s_we        = rf_write_en;
        chk("inst_ready", 64'(s_ready), 64'(exp_ready));
        chk("dispatch_en", 64'(s_en), acc ? 64'(inst_ch) : 64'd0);
        chk("rf_write_en", 64'(s_we), 64'(exp_we));
        if (alloc) chk("rd_tag", 64'(s_rd_tag), 64'(free_q[0]));
        if (acc) begin
            chk_operand("rs1", int'(inst_rs1), rf_rs1_data, s_rs1_valid, s_rs1_tag, s_rs1_data);
            chk_operand("rs2", int'(inst_rs2), rf_rs2_data, s_rs2_valid, s_rs2_tag, s_rs2_data);
        end
        @(posedge clk);
        for (int r = 0; r < NREG; r++) if (exp_we[r]) m_busy[r] = 1'b0;
        if (alloc) begin
            t = free_q.pop_front();
            m_busy[inst_rd] = 1'b1;
            m_tag[inst_rd]  = t;
            outst_q.push_back(t);
        end
        if (cdb_valid) begin
            for (int i = 0; i < outst_q.size(); i++) begin
                if (outst_q[i] == int'(cdb_tag)) begin
                    outst_q.delete(i);
                    break;
                end
            end
            free_q.push_back(int'(cdb_tag));
        end
        if (m_br && cdb_branch)                m_br = 1'b0;
        else if (!m_br && acc && inst_branch)  m_br = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        chk("reset_ready",  64'(s_ready),  64'd1);
        chk("reset_en",     64'(s_en),     64'd0);
        chk("reset_rd_tag", 64'(s_rd_tag), 64'd0);
        chk("reset_we",     64'(s_we),     64'd0);
    endtask

    task automatic set_inst(input bit rw, input int rd, input int rs1, input int ch);
        idle_inputs();
        inst_valid     = 1'b1;
        inst_reg_write = rw;
        inst_rd        = RW'(rd);
        inst_rs1       = RW'(rs1);
        inst_ch        = NCH'(1 << ch);
    endtask

    task automatic rand_inputs();
        inst_valid     = ($urandom_range(0, 3) != 0);
        inst_rd        = RW'($urandom_range(0, 7));
        inst_rs1       = RW'($urandom_range(0, 7));
        inst_rs2       = RW'($urandom_range(0, 7));
        inst_reg_write = ($urandom_range(0, 3) != 0);
        inst_ch        = NCH'(1 << $urandom_range(0, NCH - 1));
        inst_branch    = ($urandom_range(0, 7) == 0);
        rf_rs1_data    = $urandom;
        rf_rs2_data    = $urandom;
        issueque_full  = ($urandom_range(0, 3) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        if (outst_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            cdb_valid = 1'b1;
            cdb_tag   = TW'(outst_q[$urandom_range(0, outst_q.size() - 1)]);
        end
        cdb_data   = $urandom;
        cdb_branch = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Sequential allocation from reset
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            set_inst(1'b1, k, 0, CH_INT);
            step();
            chk("alloc_tag", 64'(s_rd_tag), 64'(k - 1));
        end
        set_inst(1'b0, 0, 1, CH_INT);
        step();
        chk("rst1_valid", 64'(s_rs1_valid), 64'd1);
        chk("rst1_tag",   64'(s_rs1_tag),   64'd0);

        // Rename, CDB writeback, then ready operand
        do_reset();
        set_inst(1'b1, 5, 0, CH_INT);
        step();
        set_inst(1'b0, 0, 5, CH_INT);
        step();
        chk("r5_pending", 64'(s_rs1_valid), 64'd1);
        chk("r5_tag",     64'(s_rs1_tag),   64'd0);
        idle_inputs();
        cdb_valid = 1'b1;
        cdb_tag   = '0;
        cdb_data  = 32'hDEAD;
        step();
        chk("r5_we", 64'(s_we), 64'h20);
        set_inst(1'b0, 0, 5, CH_INT);
        rf_rs1_data = 32'hCAFE;
        step();
        chk("r5_ready", 64'(s_rs1_valid), 64'd0);
        chk("r5_data",  64'(s_rs1_data),  64'hCAFE);

        // Free-list exhaustion, recycle and bypass
        do_reset();
        for (int k = 1; k <= NT; k++) begin
            set_inst(1'b1, k, 0, CH_INT);
            step();
        end
        set_inst(1'b1, 9, 0, CH_INT);
        step();
        chk("empty_ready_rw", 64'(s_ready), 64'd0);
        chk("empty_en_rw",    64'(s_en),    64'd0);
        set_inst(1'b0, 0, 0, CH_LDST);
        step();
        chk("empty_ready_st", 64'(s_ready), 64'd1);
        chk("empty_en_st",    64'(s_en),    64'(1 << CH_LDST));
        idle_inputs();
        cdb_valid = 1'b1;
        cdb_tag   = TW'(2);
        step();
        chk("recycle_we", 64'(s_we), 64'h8);
        set_inst(1'b1, 9, 0, CH_INT);
        step();
        chk("recycle_tag", 64'(s_rd_tag), 64'd2);
        set_inst(1'b0, 0, NT, CH_INT);
        rf_rs1_data = 32'h5555;
        cdb_valid   = 1'b1;
        cdb_tag     = TW'(7);
        cdb_data    = 32'h1234;
        step();
`ifdef DISPATCH_CDB_BYPASS_EN
        chk("bypass_valid", 64'(s_rs1_valid), 64'd0);
        chk("bypass_data",  64'(s_rs1_data),  64'h1234);
`else
        chk("bypass_valid", 64'(s_rs1_valid), 64'd1);
        chk("bypass_tag",   64'(s_rs1_tag),   64'd7);
`endif

        // Branch stall
        set_inst(1'b0, 0, 0, CH_INT);
        inst_branch = 1'b1;
        step();
        chk("br_accept", 64'(s_en), 64'd1);
        set_inst(1'b0, 0, 0, CH_INT);
        step();
        chk("br_wait_ready", 64'(s_ready), 64'd0);
        set_inst(1'b0, 0, 0, CH_INT);
        cdb_branch = 1'b1;
        step();
        chk("br_resolve_ready", 64'(s_ready), 64'd0);
        chk("br_resolve_en",    64'(s_en),    64'd0);
        set_inst(1'b0, 0, 0, CH_INT);
        step();
        chk("br_resume_ready", 64'(s_ready), 64'd1);
        chk("br_resume_en",    64'(s_en),    64'd1);

        // Per-channel backpressure
        set_inst(1'b0, 0, 0, CH_MUL);
        issueque_full = NCH'(1 << CH_MUL);
        step();
        chk("mul_full_ready", 64'(s_ready), 64'd0);
        chk("mul_full_en",    64'(s_en),    64'd0);
        set_inst(1'b0, 0, 0, CH_INT);
        issueque_full = NCH'(1 << CH_MUL);
        step();
        chk("int_ok_ready", 64'(s_ready), 64'd1);
        chk("int_ok_en",    64'(s_en),    64'd1);

        // Randomized traffic with occasional mid-run reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
            end else begin
                rand_inputs();
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
